keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x3 active-low matrix keypad and drives the debounced key[3:0] code that
//  keyreg and fsm consume. Outputs digits 0-9; 4'd10 (NOKEY) means idle.
//  Sits between the keypad pins and the alarm clock core, on the core clock domain.
//  Performs column scanning, frame decoding, press/release debounce and multi-key rejection.
// PARAMETERS
//  SCAN_DIV       1000  clocks per column step; row_n sampled on the last clock of each step
//  DEBOUNCE_CNT   8     consecutive identical frames needed to accept a press or a release
//  REPEAT_FRAMES  64    frames between auto-repeat pulses (used only with the macro)
//  NOKEY          4'd10 idle code driven on key
// PORTS
//  clock      in   1  core clock
//  reset      in   1  synchronous, active-high
//  row_n      in   4  keypad rows, active-low, externally pulled up
//  col_n      out  3  column drive, active-low, exactly one bit low at any time
//  key        out  4  debounced key code; NOKEY when no key is accepted
//  key_valid  out  1  one-clock pulse when key takes a new accepted value (or on a repeat)
//  key_held   out  1  high while the accepted key is held (PRESSED/RELEASE states)
// BEHAVIOUR
//  Reset: col_n=3'b110, key=NOKEY, key_valid=0, key_held=0, state=IDLE, all counters 0.
//  Reset mid-scan or mid-press: all outputs take reset values on the next clock; scan restarts at col0.
//  Scan: col index 0->1->2->0; each step lasts SCAN_DIV clocks. One frame = 3*SCAN_DIV clocks.
//  Keymap (row,col): r0:1,2,3  r1:4,5,6  r2:7,8,9  r3:*,0,#.
//  Frame result at frame end: NONE (no low rows), KEY(code) (exactly one 0-9 key low),
//   or INVALID (two or more lows, or '*'/'#'). '*' and '#' are ignored.
//  FSM, evaluated once per frame end; cand = candidate code, cnt = frame counter:
//   IDLE:     KEY(c) -> DEBOUNCE, cand=c, cnt=1. Otherwise stay.
//   DEBOUNCE: KEY(cand) -> cnt++; when cnt reaches DEBOUNCE_CNT -> PRESSED, key=cand, key_valid pulse.
//             NONE, INVALID or a different key -> IDLE, cnt=0.
//   PRESSED:  KEY(cand) -> stay. Anything else -> RELEASE, cnt=1 if NONE, else cnt=0.
//   RELEASE:  NONE -> cnt++; when cnt reaches DEBOUNCE_CNT -> IDLE, key=NOKEY.
//             KEY(cand) -> PRESSED. Another key or INVALID -> cnt=0, stay (no rollover).
//  key holds its value through PRESSED and RELEASE. key_held=1 exactly in PRESSED and RELEASE.
//  Latency: key and key_valid update 1 clock after the sample that completes the DEBOUNCE frame.
//   Press to key_valid is at most (DEBOUNCE_CNT+1) frames + 1 clock.
//  key_valid never asserts on consecutive clocks; key changes only with key_valid or on return to NOKEY.
//  Counters saturate; no wrap. Frame counter width = clog2(max(DEBOUNCE_CNT,REPEAT_FRAMES)+1).
// CONFIGURATION
//  KEYSCAN_AUTOREPEAT_EN defined:
//   In PRESSED, a repeat counter counts frames. When it reaches REPEAT_FRAMES, key_valid
//   pulses again (key unchanged) and the counter reloads to 0.
//   The counter clears on entry from DEBOUNCE and freezes in RELEASE.
//  KEYSCAN_AUTOREPEAT_EN undefined: exactly one key_valid per accepted press; no repeat logic.
// TESTING  (SCAN_DIV=2, DEBOUNCE_CNT=3, REPEAT_FRAMES=4; frame = 6 clocks)
//  1. Reset asserted 2 clocks -> col_n=110, key=10, key_valid=0, key_held=0. col_n steps 110->101->011 every 2 clocks.
//  2. Hold '5' (row1 low when col1 driven) for 6 frames -> one key_valid, key=5, key_held=1.
//     Release -> key=10, key_held=0 after 3 NONE frames.
//  3. Bounce '2': 2 frames on, 1 frame off, then 4 frames on -> exactly one key_valid, key=2.
//  4. Press '1' and '9' together for 10 frames -> key_valid never asserts, key stays 10.
//     Press '*' alone -> same result.
//  5. Hold '0' for 15 frames: with the macro -> key_valid count 1+3 (repeats every 4 frames).
//     Without the macro -> 1.
//  6. Assert reset while '7' is accepted -> key=10, key_held=0 next clock.
//     Keep '7' held after reset -> re-accepted 3 frames later with one key_valid.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x3 active-low keypad scanner: column scan, frame decode, press/release debounce.
// Define KEYSCAN_AUTOREPEAT_EN to add auto-repeat pulses on key_valid while a key is held.
module keypad_scanner #(
    parameter int         SCAN_DIV      = 1000,
    parameter int         DEBOUNCE_CNT  = 8,
    parameter int         REPEAT_FRAMES = 64,
    parameter logic [3:0] NOKEY         = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_MAX = (DEBOUNCE_CNT > REPEAT_FRAMES) ? DEBOUNCE_CNT : REPEAT_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [DIV_W-1:0] STEP_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_C     = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    // ---------------- column scan ----------------
    logic [DIV_W-1:0] step_cnt;
    logic [1:0]       col_idx;
    logic             step_last, frame_end;

    assign step_last = (step_cnt == STEP_LAST);
    assign frame_end = step_last && (col_idx == 2'd2);

    always_ff @(posedge clock) begin
        if (reset) begin
            step_cnt <= '0;
            col_idx  <= 2'd0;
        end else if (step_last) begin
            step_cnt <= '0;
            col_idx  <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
        end else begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    always_comb begin
        case (col_idx)
            2'd1:    col_n = 3'b101;
            2'd2:    col_n = 3'b011;
            default: col_n = 3'b110;
        endcase
    end

    // ---------------- frame decode ----------------
    logic [3:0] lows;
    logic [2:0] n_low, tot_raw;
    logic [3:0] cur_code, f_code, acc_code;
    logic       cur_bad, f_bad, acc_bad;
    logic [1:0] acc_n;
    logic       frame_none, frame_key;

    assign lows  = ~row_n;
    assign n_low = {2'b0, lows[0]} + {2'b0, lows[1]} + {2'b0, lows[2]} + {2'b0, lows[3]};

    // Code of the lowest-numbered low row; only meaningful when a single row is low.
    always_comb begin
        cur_code = NOKEY;
        cur_bad  = 1'b0;
        for (int r = 3; r >= 0; r--) begin
            if (lows[r]) begin
                if (r == 3) begin
                    cur_code = 4'd0;
                    cur_bad  = (col_idx != 2'd1);
                end else begin
                    cur_code = {2'b0, 2'(r)} * 4'd3 + {2'b0, col_idx} + 4'd1;
                    cur_bad  = 1'b0;
                end
            end
        end
    end

    assign tot_raw    = {1'b0, acc_n} + n_low;
    assign f_code     = (acc_n != 2'd0) ? acc_code : cur_code;
    assign f_bad      = (acc_n != 2'd0) ? acc_bad  : cur_bad;
    assign frame_none = (tot_raw == 3'd0);
    assign frame_key  = (tot_raw == 3'd1) && !f_bad;

    // Low count saturates at 2: anything above one key is already INVALID.
    always_ff @(posedge clock) begin
        if (reset || frame_end) begin
            acc_n    <= 2'd0;
            acc_code <= NOKEY;
            acc_bad  <= 1'b0;
        end else if (step_last) begin
            acc_n    <= (tot_raw >= 3'd2) ? 2'd2 : tot_raw[1:0];
            acc_code <= f_code;
            acc_bad  <= f_bad;
        end
    end

    // ---------------- debounce FSM ----------------
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [3:0]       cand, cand_nx, key_nx;
    logic             valid_nx, match;

    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
    assign match   = frame_key && (f_code == cand);

`ifdef KEYSCAN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_C = CNT_W'(REPEAT_FRAMES);
    logic [CNT_W-1:0] rep_cnt, rep_nx, rep_inc;
    assign rep_inc = (rep_cnt == CNT_SAT) ? rep_cnt : rep_cnt + 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= NOKEY;
            key       <= NOKEY;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cand      <= cand_nx;
            key       <= key_nx;
            key_valid <= valid_nx;
        end
    end

`ifdef KEYSCAN_AUTOREPEAT_EN
    always_ff @(posedge clock) begin
        if (reset) rep_cnt <= '0;
        else       rep_cnt <= rep_nx;
    end
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cand_nx  = cand;
        key_nx   = key;
        valid_nx = 1'b0;
`ifdef KEYSCAN_AUTOREPEAT_EN
        rep_nx   = rep_cnt;
`endif
        if (frame_end) begin
            case (state)
                IDLE: if (frame_key) begin
                    state_nx = DEBOUNCE;
                    cand_nx  = f_code;
                    cnt_nx   = {{(CNT_W-1){1'b0}}, 1'b1};
                end
                DEBOUNCE: if (match) begin
                    if (cnt_inc >= DEB_C) begin
                        state_nx = PRESSED;
                        key_nx   = cand;
                        valid_nx = 1'b1;
                        cnt_nx   = '0;
`ifdef KEYSCAN_AUTOREPEAT_EN
                        rep_nx   = '0;
`endif
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end else begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
                PRESSED: if (match) begin
`ifdef KEYSCAN_AUTOREPEAT_EN
                    if (rep_inc >= REP_C) begin
                        valid_nx = 1'b1;
                        rep_nx   = '0;
                    end else begin
                        rep_nx = rep_inc;
                    end
`endif
                end else begin
                    state_nx = RELEASE;
                    cnt_nx   = frame_none ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
                end
                RELEASE: if (frame_none) begin
                    if (cnt_inc >= DEB_C) begin
                        state_nx = IDLE;
                        key_nx   = NOKEY;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end else if (match) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = '0;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign key_held = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives row_n from col_n and a pressed-key mask.
module tb_keypad_scanner;
    localparam int FR = 6;  // clocks per frame with SCAN_DIV=2

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic [3:0] key;
    logic       key_valid, key_held;
    logic [11:0] pressed = '0;   // bit r*3+c = key at (row r, col c) held down

    logic [3:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    logic prev_valid = 1'b0;

    keypad_scanner #(.SCAN_DIV(2), .DEBOUNCE_CNT(3), .REPEAT_FRAMES(4), .NOKEY(4'd10)) dut (
        .clock(clock), .reset(reset), .row_n(row_n), .col_n(col_n),
        .key(key), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clock = ~clock;

    always_comb begin
        for (int r = 0; r < 4; r++)
            row_n[r] = ~|(pressed[r*3 +: 3] & ~col_n);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every key_valid pulse must match the next expected code.
    always @(negedge clock) begin
        if (key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_key_valid: got key %0d expected no pulse", key);
            end else begin
                check("key_valid_code", key, exp_q.pop_front());
            end
            if (prev_valid) begin
                checks++;
                failures++;
                $display("FAIL key_valid_consecutive: got 2 adjacent pulses expected 1");
            end
        end
        prev_valid <= (key_valid === 1'b1);
    end

    task automatic frames(input int n);
        repeat (n * FR) @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        check(name, exp_q.size(), 0);
    endtask

    int colx[6] = '{6, 5, 5, 3, 3, 6};

    initial begin
        // 1. reset values and column stepping
        repeat (2) @(posedge clock);
        #1;
        check("rst_col_n", col_n, 6);
        check("rst_key", key, 10);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            check("col_step", col_n, colx[i]);
        end

        // 2. press and release '5'
        pressed[4] = 1'b1;
        exp_q.push_back(4'd5);
        frames(3);
        check("t2_key_acc", key, 5);
        check("t2_held", key_held, 1);
        frames(3);
        pressed = '0;
        frames(2);
        check("t2_key_hold_rel", key, 5);
        check("t2_held_rel", key_held, 1);
        frames(1);
        check("t2_key_idle", key, 10);
        check("t2_held_idle", key_held, 0);
        drain("t2_queue");

        // 3. bounced '2'
        pressed[1] = 1'b1;
        frames(2);
        pressed = '0;
        frames(1);
        check("t3_key_bounce", key, 10);
        pressed[1] = 1'b1;
        exp_q.push_back(4'd2);
        frames(4);
        check("t3_key", key, 2);
        pressed = '0;
        frames(3);
        check("t3_key_idle", key, 10);
        drain("t3_queue");

        // 4. multi-key and '*' rejection
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        frames(10);
        check("t4_multi_key", key, 10);
        check("t4_multi_held", key_held, 0);
        pressed = '0;
        pressed[9] = 1'b1;
        frames(10);
        check("t4_star_key", key, 10);
        check("t4_star_held", key_held, 0);
        pressed = '0;
        frames(1);
        drain("t4_queue");

        // 5. long hold of '0'
        pressed[10] = 1'b1;
        exp_q.push_back(4'd0);
`ifdef KEYSCAN_AUTOREPEAT_EN
        repeat (3) exp_q.push_back(4'd0);
`endif
        frames(15);
        check("t5_key", key, 0);
        pressed = '0;
        frames(3);
        check("t5_key_idle", key, 10);
        drain("t5_queue");

        // 6. reset while '7' accepted, then re-accept
        pressed[6] = 1'b1;
        exp_q.push_back(4'd7);
        frames(4);
        check("t6_key_acc", key, 7);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("t6_rst_key", key, 10);
        check("t6_rst_held", key_held, 0);
        check("t6_rst_valid", key_valid, 0);
        check("t6_rst_col", col_n, 6);
        reset = 1'b0;
        exp_q.push_back(4'd7);
        frames(2);
        check("t6_not_yet", key, 10);
        frames(1);
        check("t6_key_reacc", key, 7);
        check("t6_held", key_held, 1);
        pressed = '0;
        frames(3);
        check("t6_key_idle", key, 10);
        drain("t6_queue");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
